// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the context-switching register file.
package reg_file_pkg;

  // Transfer engine states.
  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    RESTORE
  } rf_state_t;

  // Widest packed INIT vector the helper below can build.
  localparam int RF_INIT_MAX_BITS = 1024;

  // Builds a packed INIT vector one register at a time, starting from '0
  // (every register zero by default): returns init with register idx,
  // of width w, set to val.
  function automatic logic [RF_INIT_MAX_BITS-1:0] rf_init_set(
    input logic [RF_INIT_MAX_BITS-1:0] init,
    input int                          idx,
    input int                          w,
    input logic [63:0]                 val
  );
    logic [RF_INIT_MAX_BITS-1:0] res;
    res = init;
    for (int b = 0; b < w; b++) begin
      res[idx*w + b] = val[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_file_ctx_if.sv
// Core-side bus of the register file: write/read ports, context requests and
// the save/restore streams toward the data-memory arbiter.
interface reg_file_ctx_if #(
  parameter int W = 8,
  parameter int D = 3
);
  logic         WrEn;
  logic [D-1:0] WrAddr;
  logic [W-1:0] WrData;
  logic         ImmWrEn;
  logic [W-1:0] ImmData;
  logic [D-1:0] RdAddrA;
  logic [D-1:0] RdAddrB;
  logic [W-1:0] RdDataA;
  logic [W-1:0] RdDataB;
  logic         SaveReq;
  logic         RestoreReq;
  logic         Busy;
  logic         OutValid;
  logic         OutReady;
  logic [D-1:0] OutIdx;
  logic [W-1:0] OutData;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] InData;
  logic         XferDone;

  // Driven by the core / memory side.
  modport master (
    output WrEn, WrAddr, WrData, ImmWrEn, ImmData, RdAddrA, RdAddrB,
           SaveReq, RestoreReq, OutReady, InValid, InData,
    input  RdDataA, RdDataB, Busy, OutValid, OutIdx, OutData, InReady, XferDone
  );

  // Seen by the register file.
  modport slave (
    input  WrEn, WrAddr, WrData, ImmWrEn, ImmData, RdAddrA, RdAddrB,
           SaveReq, RestoreReq, OutReady, InValid, InData,
    output RdDataA, RdDataB, Busy, OutValid, OutIdx, OutData, InReady, XferDone
  );
endinterface

// File: rtl/rf_ctx_fsm.sv
// Save/restore sequencer: walks idx over all registers, one per accepted beat.
module rf_ctx_fsm
  import reg_file_pkg::*;
#(
  parameter int D = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         save_req_i,
  input  logic         restore_req_i,
  input  logic         out_ready_i,
  input  logic         in_valid_i,
  output logic         busy_o,
  output logic         out_valid_o,
  output logic         in_ready_o,
  output logic         restore_we_o,
  output logic [D-1:0] idx_o,
  output logic         xfer_done_o
);

  localparam logic [D-1:0] LAST_IDX = '1;

  rf_state_t    state_q, state_d;
  logic [D-1:0] idx_q, idx_d;
  logic         done_q, done_d;

  // State, index and done-pulse registers; synchronous reset aborts a transfer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next state and handshake outputs; a beat on the last index returns to IDLE.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_d      = state_q;
    idx_d        = idx_q;
    done_d       = 1'b0;
    out_valid_o  = 1'b0;
    in_ready_o   = 1'b0;
    restore_we_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (save_req_i) begin
          state_d = SAVE;
          idx_d   = '0;
        end else if (restore_req_i) begin
          state_d = RESTORE;
          idx_d   = '0;
        end
      end
      SAVE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + D'(1);
          end
        end
      end
      RESTORE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          restore_we_o = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + D'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign idx_o       = idx_q;
  assign xfer_done_o = done_q;

endmodule

// File: rtl/reg_file_ctx.sv
// Register file with two bypassed read ports, a general write port, an
// immediate R0 write, and a save/restore engine for context switches.
module reg_file_ctx
  import reg_file_pkg::*;
#(
  parameter int                      W    = 8,
  parameter int                      D    = 3,
  parameter logic [(2**D)*W-1:0]     INIT = '0
) (
  input logic           Clk,
  input logic           Reset,
  reg_file_ctx_if.slave bus
);

  localparam int N = 2**D;

  logic [W-1:0] regs_q [N];
  logic         busy;
  logic         restore_we;
  logic [D-1:0] idx;
  logic         gen_we;

  rf_ctx_fsm #(.D(D)) u_fsm (
    .Clk          (Clk),
    .Reset        (Reset),
    .save_req_i   (bus.SaveReq),
    .restore_req_i(bus.RestoreReq),
    .out_ready_i  (bus.OutReady),
    .in_valid_i   (bus.InValid),
    .busy_o       (busy),
    .out_valid_o  (bus.OutValid),
    .in_ready_o   (bus.InReady),
    .restore_we_o (restore_we),
    .idx_o        (idx),
    .xfer_done_o  (bus.XferDone)
  );

  // The immediate write owns R0 when both target it in the same cycle.
  assign gen_we = bus.WrEn && !(bus.ImmWrEn && (bus.WrAddr == '0));

  // Storage: restore stream while busy, core writes only while idle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: the array is reset on purpose -- each register has a defined INIT value.
      for (int i = 0; i < N; i++) begin
        regs_q[i] <= INIT[i*W +: W];
      end
    end else if (restore_we) begin
      regs_q[idx] <= bus.InData;
    end else if (!busy) begin
      if (gen_we) begin
        regs_q[bus.WrAddr] <= bus.WrData;
      end
      if (bus.ImmWrEn) begin
        regs_q[0] <= bus.ImmData;
      end
    end
  end

  // Read port A with write-through bypass while idle.
  always_comb begin
    bus.RdDataA = regs_q[bus.RdAddrA];
    if (!busy) begin
      if (bus.ImmWrEn && (bus.RdAddrA == '0)) begin
        bus.RdDataA = bus.ImmData;
      end else if (bus.WrEn && (bus.WrAddr == bus.RdAddrA)) begin
        bus.RdDataA = bus.WrData;
      end
    end
  end

  // Read port B with write-through bypass while idle.
  always_comb begin
    bus.RdDataB = regs_q[bus.RdAddrB];
    if (!busy) begin
      if (bus.ImmWrEn && (bus.RdAddrB == '0)) begin
        bus.RdDataB = bus.ImmData;
      end else if (bus.WrEn && (bus.WrAddr == bus.RdAddrB)) begin
        bus.RdDataB = bus.WrData;
      end
    end
  end

  assign bus.Busy    = busy;
  assign bus.OutIdx  = idx;
  assign bus.OutData = regs_q[idx];

endmodule

// File: tb/tb_reg_file_ctx.sv
// Randomised self-checking bench for reg_file_ctx against an array model.
module tb_reg_file_ctx;
  import reg_file_pkg::*;

  localparam int W = 8;
  localparam int D = 3;
  localparam int N = 8;
  localparam logic [N*W-1:0] INIT =
    64'(rf_init_set(rf_init_set(rf_init_set('0, 1, W, 64'd64), 4, W, 64'd9), 7, W, 64'd73));

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  reg_file_ctx_if #(.W(W), .D(D)) bus ();

  reg_file_ctx #(.W(W), .D(D), .INIT(INIT)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  int           n_pass  = 0;
  int           n_total = 0;
  logic [W-1:0] m [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic reset_model();
    for (int i = 0; i < N; i++) m[i] = INIT[i*W +: W];
  endtask

  // Expected idle read: value being written this cycle wins, immediate first.
  function automatic logic [W-1:0] exp_read(input logic [D-1:0] a);
    if (bus.ImmWrEn && a == 0) return bus.ImmData;
    if (bus.WrEn && bus.WrAddr == a) return bus.WrData;
    return m[a];
  endfunction

  // Idle write commit as seen after the next edge.
  task automatic commit_model();
    if (bus.WrEn) m[bus.WrAddr] = bus.WrData;
    if (bus.ImmWrEn) m[0] = bus.ImmData;
  endtask

  task automatic drive(input logic we, input logic [D-1:0] wa, input logic [W-1:0] wd,
                       input logic ie, input logic [W-1:0] id,
                       input logic [D-1:0] ra, input logic [D-1:0] rb);
    bus.WrEn = we; bus.WrAddr = wa; bus.WrData = wd;
    bus.ImmWrEn = ie; bus.ImmData = id;
    bus.RdAddrA = ra; bus.RdAddrB = rb;
  endtask

  task automatic drive_random_core();
    drive(1'($urandom), D'($urandom), W'($urandom), 1'($urandom), W'($urandom),
          D'($urandom), D'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int beat;
    int cyc;

    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    bus.SaveReq = 0; bus.RestoreReq = 0;
    bus.OutReady = 0; bus.InValid = 0; bus.InData = 0;
    step(); step();
    Reset = 1'b0;
    reset_model();

    // Reset state and INIT contents.
    check("rst_busy", bus.Busy, 0);
    check("rst_outvalid", bus.OutValid, 0);
    check("rst_inready", bus.InReady, 0);
    check("rst_xferdone", bus.XferDone, 0);
    for (int i = 0; i < N; i++) begin
      bus.RdAddrA = D'(i);
      #1;
      check($sformatf("rst_rd%0d", i), bus.RdDataA, m[i]);
    end
    check("rst_r1", m[1], 64);
    check("rst_r7", m[7], 73);

    // Bypass on a general write, then the stored value.
    drive(1, 3, 8'h5A, 0, 0, 3, 5);
    #1;
    check("byp_a", bus.RdDataA, 8'h5A);
    check("byp_b", bus.RdDataB, exp_read(5));
    commit_model(); step();
    drive(0, 0, 0, 0, 0, 3, 0);
    #1;
    check("stored_r3", bus.RdDataA, 8'h5A);

    // Immediate beats a general write to R0.
    drive(1, 0, 8'h11, 1, 8'h22, 0, 1);
    #1;
    check("imm_byp_r0", bus.RdDataA, 8'h22);
    commit_model(); step();
    // General write elsewhere plus immediate: both commit.
    drive(1, 2, 8'h33, 1, 8'h44, 2, 0);
    #1;
    check("dual_byp_r2", bus.RdDataA, 8'h33);
    check("dual_byp_r0", bus.RdDataB, 8'h44);
    commit_model(); step();
    drive(0, 0, 0, 0, 0, 0, 2);
    #1;
    check("dual_r0", bus.RdDataA, 8'h44);
    check("dual_r2", bus.RdDataB, 8'h33);

    // Random idle traffic.
    repeat (150) begin
      drive_random_core();
      #1;
      check("rnd_a", bus.RdDataA, exp_read(bus.RdAddrA));
      check("rnd_b", bus.RdDataB, exp_read(bus.RdAddrB));
      commit_model(); step();
    end

    // Save with stalls; core writes during the transfer must be ignored.
    drive(0, 0, 0, 0, 0, 0, 0);
    bus.SaveReq = 1;
    #1;
    check("save_pre_busy", bus.Busy, 0);
    step();
    bus.SaveReq = 0;
    beat = 0; cyc = 0;
    while (beat < N && cyc < 100) begin
      bus.OutReady = (cyc % 2 == 1) || ($urandom_range(0, 3) == 0);
      drive_random_core();
      #1;
      check("save_valid", bus.OutValid, 1);
      check("save_busy", bus.Busy, 1);
      check("save_inready", bus.InReady, 0);
      check("save_idx", bus.OutIdx, beat);
      check("save_data", bus.OutData, m[beat]);
      check("save_rd_nobyp", bus.RdDataA, m[bus.RdAddrA]);
      check("save_nodone", bus.XferDone, 0);
      step();
      if (bus.OutReady) beat++;
      cyc++;
    end
    if (beat < N) check("save_timeout", beat, N);
    bus.OutReady = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("save_done", bus.XferDone, 1);
    check("save_end_busy", bus.Busy, 0);
    check("save_end_valid", bus.OutValid, 0);
    step();
    check("save_done_once", bus.XferDone, 0);
    for (int i = 0; i < N; i++) begin
      bus.RdAddrA = D'(i);
      #1;
      check("save_regs_kept", bus.RdDataA, m[i]);
    end

    // Restore with input gaps; data 0xA0+i.
    bus.RestoreReq = 1;
    step();
    bus.RestoreReq = 0;
    beat = 0; cyc = 0;
    while (beat < N && cyc < 100) begin
      bus.InValid = ($urandom_range(0, 2) != 0);
      bus.InData  = W'(8'hA0 + beat);
      drive_random_core();
      #1;
      check("rest_ready", bus.InReady, 1);
      check("rest_busy", bus.Busy, 1);
      check("rest_outvalid", bus.OutValid, 0);
      check("rest_nodone", bus.XferDone, 0);
      step();
      if (bus.InValid) begin
        m[beat] = W'(8'hA0 + beat);
        beat++;
      end
      cyc++;
    end
    if (beat < N) check("rest_timeout", beat, N);
    bus.InValid = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rest_done", bus.XferDone, 1);
    check("rest_end_busy", bus.Busy, 0);
    step();
    check("rest_done_once", bus.XferDone, 0);
    for (int i = 0; i < N; i++) begin
      bus.RdAddrA = D'(i);
      #1;
      check($sformatf("rest_r%0d", i), bus.RdDataA, m[i]);
    end

    // Both requests: save wins; reset mid-save aborts and restores INIT.
    bus.SaveReq = 1; bus.RestoreReq = 1;
    step();
    bus.SaveReq = 0; bus.RestoreReq = 0;
    bus.OutReady = 1;
    #1;
    check("both_save_valid", bus.OutValid, 1);
    check("both_no_restore", bus.InReady, 0);
    step(); step(); step();
    check("abort_idx", bus.OutIdx, 3);
    Reset = 1;
    step();
    Reset = 0;
    bus.OutReady = 0;
    reset_model();
    check("abort_busy", bus.Busy, 0);
    check("abort_valid", bus.OutValid, 0);
    check("abort_nodone", bus.XferDone, 0);
    step();
    check("abort_nodone2", bus.XferDone, 0);
    for (int i = 0; i < N; i++) begin
      bus.RdAddrA = D'(i);
      #1;
      check($sformatf("abort_r%0d", i), bus.RdDataA, m[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
